// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared constants for the fifon read-side controller: default word and
// burst-length widths, the FSM state encoding and the skid buffer depth.
// No ports; imported by fifo_reader and fifo_reader_skid.

package fifo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LEN_WIDTH  = 8;

    // Two entries cover the FIFO's one-cycle read latency at full rate.
    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if
// Valid/ready output stream produced by fifo_reader.
//   outData  : word being presented
//   outValid : outData holds a word
//   outReady : consumer accepts the word this cycle
//   outLast  : word is the final one of the burst
// master = producer (fifo_reader), slave = consumer.

interface fifo_reader_if #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] outData;
    logic                  outValid;
    logic                  outReady;
    logic                  outLast;

    modport master (
        output outData,
        output outValid,
        output outLast,
        input  outReady
    );

    modport slave (
        input  outData,
        input  outValid,
        input  outLast,
        output outReady
    );

endinterface

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid
// Two-entry FIFO-ordered buffer that catches words returning from the
// fifon read port one cycle after RD.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   wrEn       : store wrData at the clock edge
//   wrData     : incoming word
//   pop        : drop the head entry at the clock edge
//   occ        : number of stored words (0..2)
//   headData   : oldest stored word
//   headValid  : occ != 0

module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] headData,
    output logic                  headValid
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  wrPtr;
    logic                  rdPtr;

    // Entries are cleared on reset so outData reads 0 until the first capture.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (wrEn) begin
                mem[wrPtr] <= wrData;
                wrPtr      <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            occ <= occ + {1'b0, wrEn} - {1'b0, pop};
        end
    end

    assign headData  = mem[rdPtr];
    assign headValid = (occ != 2'd0);

    // The parent's RD credit rule must keep the buffer from overflowing.
    occBound : assert property (@(posedge Clk) disable iff (!Rst_n) occ <= 2'(SKID_DEPTH));

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader
// Read-side controller for the fifon FIFO. Drains a burst of burstLen words
// by strobing RD against EMPTY and presents them on a valid/ready stream
// with outLast on the final word.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   EN         : allows new reads; buffered words drain regardless
//   Start      : one-cycle burst launch, honoured in IDLE only
//   burstLen   : words per burst, sampled with Start (0 = ignore Start)
//   EMPTY      : fifon empty flag
//   fifoData   : fifon dataOut, valid the cycle after RD
//   RD         : fifon read strobe
//   stream     : output stream (outData/outValid/outReady/outLast)
//   BUSY       : burst in progress
//   DONE       : one-cycle pulse after the last word is accepted

module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int LEN_WIDTH  = fifo_pkg::LEN_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  EN,
    input  logic                  Start,
    input  logic [LEN_WIDTH-1:0]  burstLen,
    input  logic                  EMPTY,
    input  logic [DATA_WIDTH-1:0] fifoData,
    output logic                  RD,
    fifo_reader_if.master         stream,
    output logic                  BUSY,
    output logic                  DONE
);

    state_t                 state;
    logic [LEN_WIDTH-1:0]   remIssue;
    logic [LEN_WIDTH-1:0]   remOut;
    logic                   pend;
    logic [1:0]             occ;
    logic [DATA_WIDTH-1:0]  headData;
    logic                   headValid;
    logic                   pop;
    logic [2:0]             credit;

    assign pop = headValid && stream.outReady;

    // Words that will occupy the skid buffer after this edge, counting the
    // read already in flight. A new read is allowed only while this leaves
    // room, so outReady feeds RD combinationally and full rate is kept.
    assign credit = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};

    assign RD = (state == ST_READ) && EN && !EMPTY &&
                (remIssue != '0) && (credit < 3'd2);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend <= 1'b0;
        end else begin
            pend <= RD;
        end
    end

    // FSM and burst counters. The IDLE load is written after the decrements
    // so it takes priority; RD and pop are both low in IDLE anyway.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            remIssue <= '0;
            remOut   <= '0;
        end else begin
            if (RD) begin
                remIssue <= remIssue - 1'b1;
            end
            if (pop) begin
                remOut <= remOut - 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (Start && (burstLen != '0)) begin
                        state    <= ST_READ;
                        remIssue <= burstLen;
                        remOut   <= burstLen;
                    end
                end
                ST_READ: begin
                    if (remIssue == '0) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Moving on the final pop puts DONE in the very next cycle.
                    if (pop && (remOut == LEN_WIDTH'(1))) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) skid (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .wrEn      (pend),
        .wrData    (fifoData),
        .pop       (pop),
        .occ       (occ),
        .headData  (headData),
        .headValid (headValid)
    );

    // remOut only moves on a pop, so outLast holds while the consumer stalls.
    assign stream.outData  = headData;
    assign stream.outValid = headValid;
    assign stream.outLast  = headValid && (remOut == LEN_WIDTH'(1));

    assign BUSY = (state == ST_READ) || (state == ST_FLUSH);
    assign DONE = (state == ST_DONE);

    noReadWhenEmpty : assert property (@(posedge Clk) disable iff (!Rst_n) !(RD && EMPTY));

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader
// Directed bench for fifo_reader with a behavioural fifon model on the read
// port. Each cycle inputs are driven at the falling edge and outputs sampled
// 1 time unit later; accepted words are collected and compared against
// hand-computed burst contents, ordering and timing.

module tb_fifo_reader;

    logic        Clk;
    logic        Rst_n;
    logic        EN;
    logic        Start;
    logic [7:0]  burstLen;
    logic        EMPTY;
    logic [31:0] fifoData = '0;
    logic        RD;
    logic        BUSY;
    logic        DONE;

    fifo_reader_if #(.DATA_WIDTH(32)) bus ();

    fifo_reader #(
        .DATA_WIDTH (32),
        .LEN_WIDTH  (8)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .EN       (EN),
        .Start    (Start),
        .burstLen (burstLen),
        .EMPTY    (EMPTY),
        .fifoData (fifoData),
        .RD       (RD),
        .stream   (bus),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural fifon: write port fed from the bench, registered read data.
    logic [31:0] fifoMem [0:511];
    int          fifoWr = 0;
    int          fifoRd = 0;
    logic        pushEn;
    logic [31:0] pushData;

    always @(posedge Clk) begin
        if (pushEn) begin
            fifoMem[fifoWr] <= pushData;
            fifoWr          <= fifoWr + 1;
        end
        if (RD) begin
            fifoData <= fifoMem[fifoRd];
            fifoRd   <= fifoRd + 1;
        end
    end

    assign EMPTY = (fifoWr == fifoRd);

    int          checks = 0;
    int          errors = 0;

    logic [31:0] feedQ[$];
    logic [31:0] gotData[$];
    int          cyc;
    int          rdCount, rdWhileEmpty, rdWhileDisabled;
    int          maxOcc, busyCount, doneCount, lastCount, lastIdx, holdErr;
    int          firstRd, firstValid, firstBusy, startCyc, doneCyc, lastPopCyc;
    logic        busyAtDone;
    logic        stalled;
    logic [31:0] heldData;
    logic        heldLast;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearMonitor();
        gotData.delete();
        cyc = 0; rdCount = 0; rdWhileEmpty = 0; rdWhileDisabled = 0;
        maxOcc = 0; busyCount = 0; doneCount = 0; lastCount = 0; lastIdx = -1;
        holdErr = 0; firstRd = -1; firstValid = -1; firstBusy = -1;
        startCyc = -1; doneCyc = -1; lastPopCyc = -1; busyAtDone = 1'b0;
        stalled = 1'b0; heldData = '0; heldLast = 1'b0;
    endtask

    // One clock cycle: drive inputs, feed one queued word into the FIFO,
    // then sample and record everything the checks need.
    task automatic applyStimulus(input logic ready, input logic en, input logic start,
                                 input logic [7:0] len);
        @(negedge Clk);
        bus.outReady = ready;
        EN           = en;
        Start        = start;
        burstLen     = len;
        if (feedQ.size() > 0) begin
            pushEn   = 1'b1;
            pushData = feedQ.pop_front();
        end else begin
            pushEn   = 1'b0;
        end
        #1;
        cyc++;
        if (start && startCyc < 0) startCyc = cyc;
        if (RD) begin
            rdCount++;
            if (firstRd < 0) firstRd = cyc;
        end
        if (RD && EMPTY) rdWhileEmpty++;
        if (RD && !en) rdWhileDisabled++;
        if (int'(dut.occ) > maxOcc) maxOcc = int'(dut.occ);
        if (BUSY) begin
            busyCount++;
            if (firstBusy < 0) firstBusy = cyc;
        end
        if (DONE) begin
            doneCount++;
            doneCyc    = cyc;
            busyAtDone = BUSY;
        end
        if (stalled && ((bus.outData !== heldData) || (bus.outLast !== heldLast))) holdErr++;
        if (bus.outValid && firstValid < 0) firstValid = cyc;
        if (bus.outValid && ready) begin
            gotData.push_back(bus.outData);
            if (bus.outLast) begin
                lastCount++;
                lastIdx = gotData.size() - 1;
            end
            lastPopCyc = cyc;
        end
        stalled  = bus.outValid && !ready;
        heldData = bus.outData;
        heldLast = bus.outLast;
    endtask

    task automatic feedWords(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) feedQ.push_back(base + 32'(i));
    endtask

    function automatic int orderErrors(input logic [31:0] base, input int n);
        int e = 0;
        if (gotData.size() != n) e++;
        for (int i = 0; i < n && i < gotData.size(); i++)
            if (gotData[i] !== base + 32'(i)) e++;
        return e;
    endfunction

    task automatic runToDone(input int budget);
        for (int i = 0; i < budget && doneCount == 0; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    endtask

    initial begin
        int guard;
        int sizeBefore;
        int popsWin;
        Rst_n        = 1'b0;
        EN           = 1'b0;
        Start        = 1'b0;
        burstLen     = '0;
        bus.outReady = 1'b0;
        pushEn       = 1'b0;
        pushData     = '0;
        clearMonitor();

        // Reset state
        repeat (2) @(negedge Clk);
        #1;
        checkOutput("rst_rd",    32'(RD), 32'd0);
        checkOutput("rst_valid", 32'(bus.outValid), 32'd0);
        checkOutput("rst_data",  bus.outData, 32'd0);
        checkOutput("rst_last",  32'(bus.outLast), 32'd0);
        checkOutput("rst_busy",  32'(BUSY), 32'd0);
        checkOutput("rst_done",  32'(DONE), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Test 1: basic burst of 5
        $display("[TB] test 1 basic burst");
        feedWords(32'd0, 5);
        repeat (7) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd5);
        runToDone(40);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("t1_done",      32'(doneCount), 32'd1);
        checkOutput("t1_count",     32'(gotData.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("t1_word%0d", i), (i < gotData.size()) ? gotData[i] : 32'hdead, 32'(i));
        checkOutput("t1_rdcount",   32'(rdCount), 32'd5);
        checkOutput("t1_firstrd",   32'(firstRd - startCyc), 32'd1);
        checkOutput("t1_firstval",  32'(firstValid - startCyc), 32'd3);
        checkOutput("t1_rdburst",   32'(lastPopCyc - firstRd), 32'd6);
        checkOutput("t1_lastidx",   32'(lastIdx), 32'd4);
        checkOutput("t1_lastcnt",   32'(lastCount), 32'd1);
        checkOutput("t1_donecyc",   32'(doneCyc - lastPopCyc), 32'd1);
        checkOutput("t1_busyfirst", 32'(firstBusy - startCyc), 32'd1);
        checkOutput("t1_busydone",  32'(busyAtDone), 32'd0);
        checkOutput("t1_busylen",   32'(busyCount), 32'(doneCyc - firstBusy));
        checkOutput("t1_empty",     32'(EMPTY), 32'd1);

        // Test 2: backpressure with outReady pattern 1,0,0,1
        $display("[TB] test 2 backpressure");
        feedWords(32'h20, 8);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd8);
        for (int k = 1; k < 80 && doneCount == 0; k++)
            applyStimulus(((k % 4) == 0) || ((k % 4) == 3), 1'b1, 1'b0, 8'd0);
        checkOutput("t2_order",   32'(orderErrors(32'h20, 8)), 32'd0);
        checkOutput("t2_hold",    32'(holdErr), 32'd0);
        checkOutput("t2_maxocc",  32'(maxOcc <= 2), 32'd1);
        checkOutput("t2_lastidx", 32'(lastIdx), 32'd7);
        checkOutput("t2_lastcnt", 32'(lastCount), 32'd1);
        checkOutput("t2_done",    32'(doneCount), 32'd1);

        // Test 3: underflow stall, then the missing words arrive
        $display("[TB] test 3 underflow stall");
        feedWords(32'h40, 2);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd4);
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("t3_partial", 32'(gotData.size()), 32'd2);
        checkOutput("t3_rdempty", 32'(rdWhileEmpty), 32'd0);
        checkOutput("t3_busy",    32'(BUSY), 32'd1);
        checkOutput("t3_nodone",  32'(doneCount), 32'd0);
        checkOutput("t3_nolast",  32'(lastCount), 32'd0);
        feedWords(32'h42, 2);
        runToDone(30);
        checkOutput("t3_order",   32'(orderErrors(32'h40, 4)), 32'd0);
        checkOutput("t3_lastidx", 32'(lastIdx), 32'd3);
        checkOutput("t3_done",    32'(doneCount), 32'd1);

        // Test 4: EN low mid-burst, ignored Start, zero-length Start
        $display("[TB] test 4 enable and start gating");
        feedWords(32'h50, 10);
        repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd10);
        sizeBefore = 0;
        popsWin    = 0;
        for (int k = 1; k < 60 && doneCount == 0; k++) begin
            if (k == 4) sizeBefore = gotData.size();
            applyStimulus(1'b1, !((k >= 4) && (k < 9)), (k == 2), (k == 2) ? 8'd3 : 8'd10);
            if (k == 8) popsWin = gotData.size() - sizeBefore;
        end
        checkOutput("t4_rdoff",   32'(rdWhileDisabled), 32'd0);
        checkOutput("t4_drain",   32'(popsWin), 32'd2);
        checkOutput("t4_order",   32'(orderErrors(32'h50, 10)), 32'd0);
        checkOutput("t4_lastidx", 32'(lastIdx), 32'd9);
        checkOutput("t4_done",    32'(doneCount), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd0);
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        checkOutput("t4_len0busy", 32'(busyCount), 32'd0);
        checkOutput("t4_len0rd",   32'(rdCount), 32'd0);

        // Test 5: asynchronous reset after 3 of 6 words
        $display("[TB] test 5 reset mid-burst");
        feedWords(32'h60, 6);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd6);
        guard = 0;
        while (gotData.size() < 3 && guard < 40) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
            guard++;
        end
        checkOutput("t5_three", 32'(gotData.size()), 32'd3);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        checkOutput("t5_rd",    32'(RD), 32'd0);
        checkOutput("t5_valid", 32'(bus.outValid), 32'd0);
        checkOutput("t5_data",  bus.outData, 32'd0);
        checkOutput("t5_last",  32'(bus.outLast), 32'd0);
        checkOutput("t5_busy",  32'(BUSY), 32'd0);
        checkOutput("t5_done",  32'(DONE), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        // Words 0x60..0x64 left the FIFO before reset; 0x65 is still queued.
        feedWords(32'h66, 1);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd2);
        runToDone(30);
        checkOutput("t5_order",   32'(orderErrors(32'h65, 2)), 32'd0);
        checkOutput("t5_lastidx", 32'(lastIdx), 32'd1);
        checkOutput("t5_redone",  32'(doneCount), 32'd1);

        // Test 6: maximum burst length
        $display("[TB] test 6 max length");
        clearMonitor();
        feedWords(32'h1000, 255);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd255);
        runToDone(1000);
        checkOutput("t6_count",   32'(gotData.size()), 32'd255);
        checkOutput("t6_order",   32'(orderErrors(32'h1000, 255)), 32'd0);
        checkOutput("t6_lastidx", 32'(lastIdx), 32'd254);
        checkOutput("t6_lastcnt", 32'(lastCount), 32'd1);
        checkOutput("t6_rdcount", 32'(rdCount), 32'd255);
        checkOutput("t6_done",    32'(doneCount), 32'd1);
        checkOutput("t6_maxocc",  32'(maxOcc <= 2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the `fifon` synchronous FIFO: drains bursts of words by driving `RD` against `EMPTY` and presents them on a valid/ready output stream with end-of-burst marking. It sits between the FIFO's read port (`RD`, `dataOut`, `EMPTY`) and a downstream consumer. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so throughput is one word per cycle under continuous `outReady`.

## Interface
- `DATA_WIDTH`, 32, word width; must match the FIFO.
- `LEN_WIDTH`, 8, width of the burst-length field.
- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `EN` in 1: enable. While low, no new `RD` is issued; in-flight and buffered words still drain.
- `Start` in 1: one-cycle pulse that launches a burst. Sampled in IDLE only.
- `burstLen` in LEN_WIDTH: words per burst, sampled on `Start`. A value of 0 means `Start` is ignored.
- `EMPTY` in 1: FIFO empty flag.
- `fifoData` in DATA_WIDTH: FIFO `dataOut`. Valid in the cycle after `RD` is high.
- `RD` out 1: FIFO read strobe.
- `outData` out DATA_WIDTH; `outValid` out 1; `outReady` in 1; `outLast` out 1 (high on the final word of the burst).
- `BUSY` out 1: high from the cycle after an accepted `Start` until the cycle `DONE` pulses.
- `DONE` out 1: one-cycle pulse after the last-word handshake.

## Operation
- **Reset.** All outputs are 0 on reset: `RD`, `outData`, `outValid`, `outLast`, `BUSY`, `DONE`. State returns to IDLE, counters clear, and the skid buffer empties. Buffered words are discarded. Words not yet read stay in the FIFO.
- **States.**
  - IDLE → READ on `Start && burstLen != 0`. Latch `remIssue = remOut = burstLen`.
  - READ → FLUSH when `remIssue` reaches 0.
  - FLUSH → DONE when `remOut` reaches 0.
  - DONE → IDLE unconditionally after 1 cycle, with `DONE = 1`.
- **Read strobe.** `RD = (state == READ) && EN && !EMPTY && remIssue != 0 && (occ + pend - pop) < 2`.
  - `occ` is the skid occupancy (0..2).
  - `pend` is `RD` registered from the previous cycle.
  - `pop = outValid && outReady`.
  - The path from `outReady` to `RD` is combinational and allowed. `RD` must never be high while `EMPTY` is high.
- **Counters.** `remIssue` decrements on every `RD`. `remOut` decrements on every `pop`.
- **Capture.** When `pend == 1`, `fifoData` is written into the skid buffer at the clock edge.
- **Output.** The skid buffer is FIFO-ordered. `outData` and `outValid` come from the head entry. `outLast = outValid && (remOut == 1)`.
- **Output hold rule.** While `outValid && !outReady`, `outData` and `outLast` hold stable.
- **Ignored starts.** `Start` outside IDLE is ignored, with no effect on counters.
- **EN deassert mid-burst.** Issuing pauses and the burst resumes when `EN` returns. `BUSY` stays high.
- **EMPTY mid-burst.** Issuing stalls with no timeout. The burst completes only when enough words arrive.
- **Overflow.** Skid overflow is impossible by the `RD` rule. Verify with an assertion on `occ <= 2`.
- **Width rule.** Counters are LEN_WIDTH wide. `burstLen = 2^LEN_WIDTH - 1` is the maximum burst.

## Timing
- **Start to first read.** `Start` sampled at edge k; the first `RD` can be high in cycle k+1.
- **Read latency.** `RD` high in cycle t gives `fifoData` valid in t+1, captured at the end of t+1, and `outValid` high in t+2.
- **Start-to-first-valid.** 3 cycles.
- **Steady state.** With `outReady = 1` and `!EMPTY`, one `RD` and one pop per cycle.
- **Completion.** Last pop at edge m gives `DONE = 1` in cycle m+1 and `BUSY = 0` from cycle m+1. A new `Start` is accepted from cycle m+2 (IDLE).
- **Backpressure.** `outReady` low for N cycles allows at most 2 words buffered. `RD` stops within the same cycle the credit is exhausted.

## Structure
- Shared package `fifo_pkg`:
  - `DATA_WIDTH` default.
  - State encoding constants: IDLE = 2'd0, READ = 2'd1, FLUSH = 2'd2, DONE = 2'd3.
  - Skid depth constant (2).
- Sub-module `fifo_reader_skid`: the 2-entry buffer. Ports are write-enable/data, pop, `occ`, head data and valid.
- Parent `fifo_reader`: FSM, counters and the `RD` logic.

## Test plan
1. **Basic burst.** Preload FIFO with 0,1,2,3,4; `Start`, `burstLen = 5`; `outReady = 1`. Expect `RD` for 5 consecutive cycles, `outData` 0..4 on consecutive cycles, `outLast` only with 4, `DONE` pulse once, FIFO `EMPTY` afterwards.
2. **Backpressure.** 8 words, `burstLen = 8`, `outReady` toggling 1,0,0,1 repeatedly. Expect order 0..7 preserved, `outData` stable while stalled, `occ` never exceeding 2, no lost or duplicated word.
3. **Underflow stall.** `burstLen = 4` with only 2 words present. Expect 2 words out, `RD` low while `EMPTY`, `BUSY` held. Write 2 more words: remaining words emerge, `outLast` on the 4th, then `DONE`.
4. **Enable and start gating.** `EN` low for 5 cycles mid-burst: no `RD` during that window, buffered words still drain, burst resumes. `Start` during the burst is ignored. `burstLen = 0` gives no `BUSY`.
5. **Reset mid-burst.** Assert `Rst_n = 0` asynchronously after 3 of 6 words. Expect all outputs 0 immediately. After release, IDLE; a new `Start`, `burstLen = 2` delivers the next FIFO words correctly.
6. **Max length.** `burstLen = 255` with continuous data. Expect exactly 255 pops, `outLast` on the 255th, and counters not wrapping.
